// File: rtl/gb_timer_pkg.sv
// Shared constants, state encoding and helpers for the gb_timer peripheral.
package gb_timer_pkg;

    localparam logic [1:0] DIV_OFS  = 2'd0;
    localparam logic [1:0] TIMA_OFS = 2'd1;
    localparam logic [1:0] TMA_OFS  = 2'd2;
    localparam logic [1:0] TAC_OFS  = 2'd3;

    localparam logic [7:0] TAC_RD_MASK = 8'hF8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OVF_WAIT = 2'd1,
        RELOAD   = 2'd2
    } state_e;

    // Maps the TAC clock-select field onto the system counter bit that drives TIMA.
    function automatic logic [3:0] tap_sel(input logic [1:0] clk_sel);
        logic [3:0] tap;
        case (clk_sel)
            2'b00:   tap = 4'd9;
            2'b01:   tap = 4'd3;
            2'b10:   tap = 4'd5;
            2'b11:   tap = 4'd7;
            default: tap = 4'd9;
        endcase
        return tap;
    endfunction

endpackage

// File: rtl/gb_timer_if.sv
// Register bus between the CPU core (master) and the timer (slave), plus the IRQ line.
interface gb_timer_if;

    logic       cen_i;
    logic       sel_i;
    logic [1:0] addr_i;
    logic       wr_i;
    logic [7:0] wdata_i;
    logic [7:0] rdata_o;
    logic       irq_o;

    modport master (
        output cen_i,
        output sel_i,
        output addr_i,
        output wr_i,
        output wdata_i,
        input  rdata_o,
        input  irq_o
    );

    modport slave (
        input  cen_i,
        input  sel_i,
        input  addr_i,
        input  wr_i,
        input  wdata_i,
        output rdata_o,
        output irq_o
    );

endinterface

// File: rtl/gb_timer_divider.sv
// Free-running system counter with DIV clear, TAC tap mux and falling-edge detector.
module gb_timer_divider
    import gb_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cen,
    input  logic       i_div_clr,
    input  logic [2:0] i_tac,
    output logic [7:0] o_div,
    output logic       o_inc_pulse
);

    logic [CNT_W-1:0] r_sys_cnt;
    logic             r_prev_tsig;
    logic [3:0]       w_tap;
    logic             w_tsig;

    assign w_tap  = tap_sel(i_tac[1:0]);
    assign w_tsig = i_tac[2] & r_sys_cnt[w_tap];

    // Counter and previous tap level; a DIV clear or TAC change that drops the tap
    // level is seen as a falling edge, matching the original silicon glitch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sys_cnt   <= '0;
            r_prev_tsig <= 1'b0;
        end else if (i_cen) begin
            r_sys_cnt   <= i_div_clr ? '0 : r_sys_cnt + CNT_W'(1);
            r_prev_tsig <= w_tsig;
        end else begin
            r_sys_cnt   <= r_sys_cnt;
            r_prev_tsig <= r_prev_tsig;
        end
    end

    assign o_inc_pulse = i_cen & r_prev_tsig & ~w_tsig;
    assign o_div       = r_sys_cnt[CNT_W-1 -: 8];

endmodule

// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer peripheral: register file, overflow/reload FSM and bus decode.
module gb_timer
    import gb_timer_pkg::*;
#(
    parameter int OVF_DELAY = 4,
    parameter int CNT_W     = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    gb_timer_if.slave  bus
);

    localparam int DLY_W = (OVF_DELAY > 1) ? $clog2(OVF_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(OVF_DELAY - 1);

    logic [7:0]       r_tima;
    logic [7:0]       r_tma;
    logic [2:0]       r_tac;
    state_e           r_state;
    logic [DLY_W-1:0] r_dly;
    logic             r_irq;

    logic             w_wr_en;
    logic             w_wr_div;
    logic             w_wr_tima;
    logic             w_wr_tma;
    logic             w_wr_tac;
    logic             w_inc;
    logic [7:0]       w_div;
    logic [7:0]       w_rdata;
    logic [7:0]       w_tima_nxt;
    logic [7:0]       w_tma_nxt;
    state_e           w_state_nxt;
    logic [DLY_W-1:0] w_dly_nxt;
    logic             w_irq_nxt;

    assign w_wr_en   = bus.cen_i & bus.sel_i & bus.wr_i;
    assign w_wr_div  = w_wr_en & (bus.addr_i == DIV_OFS);
    assign w_wr_tima = w_wr_en & (bus.addr_i == TIMA_OFS);
    assign w_wr_tma  = w_wr_en & (bus.addr_i == TMA_OFS);
    assign w_wr_tac  = w_wr_en & (bus.addr_i == TAC_OFS);

    gb_timer_divider #(
        .CNT_W (CNT_W)
    ) u_divider (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_cen       (bus.cen_i),
        .i_div_clr   (w_wr_div),
        .i_tac       (r_tac),
        .o_div       (w_div),
        .o_inc_pulse (w_inc)
    );

    // Next-state logic; in RELOAD the reload takes priority over any increment.
    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly;
        w_tima_nxt  = r_tima;
        w_tma_nxt   = w_wr_tma ? bus.wdata_i : r_tma;
        w_irq_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_wr_tima) begin
                    w_tima_nxt = bus.wdata_i;
                end else if (w_inc) begin
                    if (r_tima == 8'hFF) begin
                        w_tima_nxt  = 8'h00;
                        w_state_nxt = OVF_WAIT;
                        w_dly_nxt   = DLY_INIT;
                    end else begin
                        w_tima_nxt = r_tima + 8'd1;
                    end
                end else begin
                    w_tima_nxt = r_tima;
                end
            end
            OVF_WAIT: begin
                if (w_wr_tima) begin
                    w_tima_nxt  = bus.wdata_i;
                    w_state_nxt = IDLE;
                end else if (w_inc && (r_tima == 8'hFF)) begin
                    w_tima_nxt = 8'h00;
                    w_dly_nxt  = DLY_INIT;
                end else begin
                    w_tima_nxt = w_inc ? (r_tima + 8'd1) : r_tima;
                    w_dly_nxt  = r_dly - DLY_W'(1);
                    if (r_dly <= DLY_W'(1)) begin
                        w_state_nxt = RELOAD;
                    end else begin
                        w_state_nxt = OVF_WAIT;
                    end
                end
            end
            RELOAD: begin
                w_tima_nxt  = w_tma_nxt;
                w_irq_nxt   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Register file and FSM state; everything holds while cen_i is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tima  <= 8'h00;
            r_tma   <= 8'h00;
            r_tac   <= 3'b000;
            r_state <= IDLE;
            r_dly   <= '0;
            r_irq   <= 1'b0;
        end else if (bus.cen_i) begin
            r_tima  <= w_tima_nxt;
            r_tma   <= w_tma_nxt;
            r_tac   <= w_wr_tac ? bus.wdata_i[2:0] : r_tac;
            r_state <= w_state_nxt;
            r_dly   <= w_dly_nxt;
            r_irq   <= w_irq_nxt;
        end else begin
            r_tima  <= r_tima;
            r_tma   <= r_tma;
            r_tac   <= r_tac;
            r_state <= r_state;
            r_dly   <= r_dly;
            r_irq   <= r_irq;
        end
    end

    // Side-effect-free read mux; an unselected bus reads as open (all ones).
    always_comb begin
        w_rdata = 8'hFF;
        if (bus.sel_i) begin
            case (bus.addr_i)
                DIV_OFS:  w_rdata = w_div;
                TIMA_OFS: w_rdata = r_tima;
                TMA_OFS:  w_rdata = r_tma;
                TAC_OFS:  w_rdata = TAC_RD_MASK | {5'b00000, r_tac};
                default:  w_rdata = 8'hFF;
            endcase
        end else begin
            w_rdata = 8'hFF;
        end
    end

    assign bus.rdata_o = w_rdata;
    assign bus.irq_o   = r_irq;

endmodule

// File: tb/tb_gb_timer.sv
// Scoreboard bench for gb_timer: directed scenarios plus random traffic against a cycle model.
module tb_gb_timer;

    localparam int OVF_DELAY = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gb_timer_if bus();

    gb_timer #(.OVF_DELAY(OVF_DELAY), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rdata;
        logic       irq;
        logic       has_c;
        logic [7:0] cval;
        string      name;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int irq_seen = 0;
    int irq_cyc = -1;
    int cyc_n = 0;

    // Reference model state: plain integers, pending reload as a countdown (-1 = none).
    int m_cnt, m_tima, m_tma, m_tac, m_pend;
    bit m_prev, m_irq;

    function automatic void m_reset();
        m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_pend = -1;
        m_prev = 1'b0; m_irq = 1'b0;
    endfunction

    function automatic logic [7:0] m_read(input bit sel, input logic [1:0] a);
        if (!sel) return 8'hFF;
        case (a)
            2'd0:    return 8'((m_cnt >> 8) & 255);
            2'd1:    return 8'(m_tima);
            2'd2:    return 8'(m_tma);
            default: return 8'(248 | m_tac);
        endcase
    endfunction

    function automatic void m_step(input bit w, input logic [1:0] a, input logic [7:0] d);
        int tap;
        bit tsig, fall, reload;
        tap    = ((m_tac & 3) == 0) ? 9 : 1 + 2 * (m_tac & 3);
        tsig   = (((m_tac >> 2) & 1) != 0) && (((m_cnt >> tap) & 1) != 0);
        fall   = m_prev && !tsig;
        reload = (m_pend == 0);
        if (w && a == 2'd2) m_tma = int'(d);
        if (reload) begin
            m_tima = m_tma;
            m_pend = -1;
        end else if (w && a == 2'd1) begin
            m_tima = int'(d);
            m_pend = -1;
        end else if (fall && m_tima == 255) begin
            m_tima = 0;
            m_pend = OVF_DELAY - 1;
        end else begin
            if (fall) m_tima = m_tima + 1;
            if (m_pend > 0) m_pend = m_pend - 1;
        end
        if (w && a == 2'd3) m_tac = int'(d) & 7;
        m_irq  = reload;
        m_prev = tsig;
        m_cnt  = (w && a == 2'd0) ? 0 : (m_cnt + 1) % 65536;
    endfunction

    task automatic check8(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", nm, got, exp, cyc_n);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Monitor: compares each presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check8({e.name, "_model"}, bus.rdata_o, e.rdata);
                check8("irq", {7'd0, bus.irq_o}, {7'd0, e.irq});
                if (e.has_c) check8(e.name, bus.rdata_o, e.cval);
                if (bus.irq_o && bus.cen_i) begin
                    irq_seen++;
                    irq_cyc = cyc_n;
                end
            end
        end
    end

    task automatic cyc(input bit cen, input bit sel, input bit wr, input logic [1:0] a,
                       input logic [7:0] d, input bit has_c, input logic [7:0] cval,
                       input string nm);
        exp_t e;
        cyc_n++;
        bus.cen_i = cen; bus.sel_i = sel; bus.wr_i = wr; bus.addr_i = a; bus.wdata_i = d;
        e.rdata = m_read(sel, a);
        e.irq   = m_irq;
        e.has_c = has_c;
        e.cval  = cval;
        e.name  = nm;
        q.push_back(e);
        if (cen) m_step(sel && wr, a, d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, "idle");
    endtask
    task automatic rd(input logic [1:0] a);
        cyc(1'b1, 1'b1, 1'b0, a, 8'h00, 1'b0, 8'h00, "rd");
    endtask
    task automatic rdc(input logic [1:0] a, input logic [7:0] v, input string nm);
        cyc(1'b1, 1'b1, 1'b0, a, 8'h00, 1'b1, v, nm);
    endtask
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b1, 1'b1, a, d, 1'b0, 8'h00, "wr");
    endtask

    task automatic do_reset();
        bus.cen_i = 1'b0; bus.sel_i = 1'b0; bus.wr_i = 1'b0;
        rst = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic arm(input logic [7:0] tac, input logic [7:0] tima, input logic [7:0] tma);
        wr(2'd3, 8'h00);
        repeat (8) idle();
        wr(2'd0, 8'h00);
        wr(2'd3, tac);
        wr(2'd2, tma);
        wr(2'd1, tima);
    endtask

    task automatic wait_pend(input int target);
        int n = 0;
        while (m_pend != target && n < 200) begin
            rd(2'd1);
            n++;
        end
    endtask

    initial begin
        int base, ovf_cyc, p;
        bit c, s, w;
        logic [1:0] a;
        logic [7:0] d;
        bus.cen_i = 1'b0; bus.sel_i = 1'b0; bus.wr_i = 1'b0;
        bus.addr_i = 2'd0; bus.wdata_i = 8'h00;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values and DIV after 256 enabled cycles.
        rdc(2'd3, 8'hF8, "tac_rst");
        rdc(2'd1, 8'h00, "tima_rst");
        rdc(2'd2, 8'h00, "tma_rst");
        repeat (252) idle();
        rdc(2'd0, 8'h00, "div_255");
        rdc(2'd0, 8'h01, "div_256");
        wr(2'd0, 8'hAB);
        rdc(2'd0, 8'h00, "div_clr");

        // Overflow: 4 cycles of 00, then TMA reload with a single IRQ pulse.
        arm(8'h05, 8'hFE, 8'h42);
        base = irq_seen;
        ovf_cyc = -1;
        p = 0;
        while (m_pend != OVF_DELAY - 1 && p < 200) begin
            rd(2'd1);
            p++;
        end
        ovf_cyc = cyc_n;
        repeat (4) rdc(2'd1, 8'h00, "tima_ovf_zero");
        rdc(2'd1, 8'h42, "tima_reload");
        repeat (4) rd(2'd1);
        chk_int("irq_pulses", irq_seen - base, 1);
        chk_int("irq_latency", irq_cyc - ovf_cyc, OVF_DELAY + 1);

        // TIMA write during OVF_WAIT cancels reload and IRQ.
        arm(8'h05, 8'hFE, 8'h42);
        base = irq_seen;
        wait_pend(OVF_DELAY - 1);
        rdc(2'd1, 8'h00, "tima_wait_zero");
        wr(2'd1, 8'h10);
        repeat (8) rd(2'd1);
        rdc(2'd1, 8'h10, "tima_cancel");
        chk_int("irq_cancel", irq_seen - base, 0);

        // TMA write-through in RELOAD, then TIMA write ignored in RELOAD.
        arm(8'h05, 8'hFE, 8'h42);
        base = irq_seen;
        wait_pend(0);
        wr(2'd2, 8'h77);
        rdc(2'd1, 8'h77, "tima_tma_wt");
        chk_int("irq_wt", irq_seen - base, 1);
        arm(8'h05, 8'hFF, 8'h55);
        wait_pend(0);
        wr(2'd1, 8'h33);
        rdc(2'd1, 8'h55, "tima_wr_in_reload");

        // DIV write with the bit-9 tap high glitches TIMA; not when timer disabled.
        arm(8'h04, 8'h20, 8'h00);
        repeat (600) idle();
        rdc(2'd1, 8'h20, "tima_pre_div");
        wr(2'd0, 8'h00);
        idle();
        rdc(2'd1, 8'h21, "div_glitch");
        arm(8'h00, 8'h20, 8'h00);
        repeat (600) idle();
        wr(2'd0, 8'h00);
        idle();
        rdc(2'd1, 8'h20, "div_no_glitch");

        // Reset during OVF_WAIT: registers cleared, no IRQ.
        arm(8'h05, 8'hFF, 8'h42);
        wait_pend(OVF_DELAY - 2);
        base = irq_seen;
        do_reset();
        rdc(2'd1, 8'h00, "tima_after_rst");
        rdc(2'd2, 8'h00, "tma_after_rst");
        rdc(2'd3, 8'hF8, "tac_after_rst");
        repeat (20) rd(2'd1);
        chk_int("irq_after_rst", irq_seen - base, 0);

        // cen_i low freezes state and blocks writes.
        wr(2'd1, 8'h5A);
        repeat (10) cyc(1'b0, 1'b1, 1'b1, 2'd1, 8'hEE, 1'b1, 8'h5A, "tima_frozen");
        repeat (10) cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, "div_frozen");
        rdc(2'd1, 8'h5A, "tima_after_freeze");

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            c = ($urandom % 10) != 0;
            s = ($urandom % 4) != 0;
            a = 2'($urandom % 4);
            w = ($urandom % 5) == 0;
            if (a == 2'd0 && ($urandom % 8) != 0) w = 1'b0;
            d = ($urandom % 2) ? 8'(8'hFC + ($urandom % 4)) : 8'($urandom % 256);
            cyc(c, s, w, a, d, 1'b0, 8'h00, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
